// File: rtl/hdmi_hist_pkg.sv
// Shared constants, FSM state type and luma helper for the per-frame
// luminance histogram.
package hdmi_hist_pkg;

    localparam int NBINS = 256;
    localparam int BIN_W = 8;

    localparam int unsigned LUMA_R = 77;
    localparam int unsigned LUMA_G = 150;
    localparam int unsigned LUMA_B = 29;

    typedef enum logic [1:0] {
        CLEAR,
        WAIT_VS,
        ACCUM,
        DRAIN
    } hist_state_e;

    // The three weights sum to 256, so the top byte of the weighted sum is the luma.
    function automatic logic [BIN_W-1:0] luma(input logic [23:0] rgb);
        int unsigned y;
        y = LUMA_R * rgb[23:16] + LUMA_G * rgb[15:8] + LUMA_B * rgb[7:0];
        return BIN_W'(y >> BIN_W);
    endfunction

endpackage

// File: rtl/hdmi_hist_accum_if.sv
// Video input, bin readout and status signals of the histogram block.
interface hdmi_hist_accum_if #(
    parameter int CNT_W = 22
);
    logic             en;
    logic [23:0]      vid_rgb;
    logic             vid_de;
    logic             vid_vs;
    logic             rd_en;
    logic [7:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic             hist_ready;
    logic             frame_done;
    logic             drop_err;
    logic             err_clr;

    modport master (
        output en, vid_rgb, vid_de, vid_vs, rd_en, rd_addr, err_clr,
        input  rd_data, rd_valid, hist_ready, frame_done, drop_err
    );

    modport slave (
        input  en, vid_rgb, vid_de, vid_vs, rd_en, rd_addr, err_clr,
        output rd_data, rd_valid, hist_ready, frame_done, drop_err
    );
endinterface

// File: rtl/hist_bank_ram.sv
// Two-bank histogram store: side A reads and writes the accumulating bank,
// side B reads the completed bank. All reads have one cycle of latency.
module hist_bank_ram #(
    parameter int DATA_W = 22,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_waddr,
    input  logic [DATA_W-1:0] i_a_wdata,
    input  logic              i_a_re,
    input  logic [ADDR_W-1:0] i_a_raddr,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_re,
    input  logic [ADDR_W-1:0] i_b_raddr,
    output logic [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    // NOTE: no reset here, so the array maps onto block RAM; banks are cleared by the FSM.
    always_ff @(posedge clk) begin
        if (i_a_we) r_mem[i_a_waddr] <= i_a_wdata;
        if (i_a_re) r_a_rdata <= r_mem[i_a_raddr];
        if (i_b_re) r_b_rdata <= r_mem[i_b_raddr];
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/hdmi_hist_accum.sv
// Per-frame luma histogram with ping-pong banks: one bank counts the current
// frame while the other serves reads of the last completed frame.
module hdmi_hist_accum
    import hdmi_hist_pkg::*;
#(
    parameter int CNT_W  = 22,
    parameter bit VS_POL = 1'b1
) (
    input logic               clk,
    input logic               rst,
    hdmi_hist_accum_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hist_state_e      r_state, w_state_nxt;
    logic             r_bank, r_from_drain;
    logic [BIN_W-1:0] r_clr_cnt;
    logic             r_vs_d, r_vs_edge;
    logic             r_s1_vld, r_s2_vld, r_s3_vld, r_s4_vld;
    logic [BIN_W-1:0] r_s1_y, r_s2_y, r_s3_y, r_s4_y;
    logic [CNT_W-1:0] r_s3_cnt, r_s4_cnt;
    logic             r_hist_ready, r_frame_done, r_drop_err, r_rd_valid, r_rd_mask;
    logic             w_swap, w_drop, w_pipe_empty, w_ram_we;
    logic [BIN_W:0]   w_ram_waddr;
    logic [CNT_W-1:0] w_ram_wdata, w_acc_rdata, w_rd_rdata, w_old, w_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d    <= VS_POL;
            r_vs_edge <= 1'b0;
        end else begin
            r_vs_d    <= bus.vid_vs;
            r_vs_edge <= (bus.vid_vs == VS_POL) && (r_vs_d != VS_POL);
        end
    end

    assign w_pipe_empty = !(r_s1_vld || r_s2_vld || r_s3_vld);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        unique case (r_state)
            CLEAR:   if (r_clr_cnt == BIN_W'(NBINS - 1))
                         w_state_nxt = (r_from_drain && bus.en) ? ACCUM : WAIT_VS;
            WAIT_VS: if (r_vs_edge && bus.en) w_state_nxt = ACCUM;
            ACCUM:   if (r_vs_edge) w_state_nxt = DRAIN;
            DRAIN:   if (w_pipe_empty) begin
                         w_swap      = 1'b1;
                         w_state_nxt = CLEAR;
                     end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= CLEAR;
            r_clr_cnt    <= '0;
            r_bank       <= 1'b0;
            r_from_drain <= 1'b0;
            r_hist_ready <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_cnt    <= (r_state == CLEAR) ? r_clr_cnt + 1'b1 : '0;
            r_frame_done <= w_swap;
            if (w_swap) begin
                r_bank       <= ~r_bank;
                r_hist_ready <= 1'b1;
                r_from_drain <= 1'b1;
            end
        end
    end

    // Only the valid bits need a reset; the payload is ignored while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
            r_s4_vld <= 1'b0;
        end else begin
            r_s1_vld <= bus.vid_de && (r_state == ACCUM);
            r_s2_vld <= r_s1_vld;
            r_s3_vld <= r_s2_vld;
            r_s4_vld <= r_s3_vld;
        end
    end

    always_ff @(posedge clk) begin
        r_s1_y   <= luma(bus.vid_rgb);
        r_s2_y   <= r_s1_y;
        r_s3_y   <= r_s2_y;
        r_s3_cnt <= w_new;
        r_s4_y   <= r_s3_y;
        r_s4_cnt <= r_s3_cnt;
    end

    // S4 covers the write that lands on the same edge as the S2 read; S3 is newer and wins.
    always_comb begin
        w_old = w_acc_rdata;
        if (r_s4_vld && (r_s4_y == r_s2_y)) w_old = r_s4_cnt;
        if (r_s3_vld && (r_s3_y == r_s2_y)) w_old = r_s3_cnt;
        w_new = (w_old == CNT_MAX) ? CNT_MAX : w_old + CNT_W'(1);
    end

    always_comb begin
        w_ram_we    = r_s3_vld;
        w_ram_waddr = {r_bank, r_s3_y};
        w_ram_wdata = r_s3_cnt;
        if (r_state == CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = {r_bank, r_clr_cnt};
            w_ram_wdata = '0;
        end
    end

    assign w_drop = bus.vid_de && ((r_state == CLEAR) || (r_state == DRAIN) ||
                                   ((r_state == WAIT_VS) && bus.en));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_err <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_mask  <= 1'b1;
        end else begin
            if (w_drop)           r_drop_err <= 1'b1;
            else if (bus.err_clr) r_drop_err <= 1'b0;
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) r_rd_mask <= !r_hist_ready;
        end
    end

    hist_bank_ram #(
        .DATA_W (CNT_W),
        .ADDR_W (BIN_W + 1)
    ) u_ram (
        .clk       (clk),
        .i_a_we    (w_ram_we),
        .i_a_waddr (w_ram_waddr),
        .i_a_wdata (w_ram_wdata),
        .i_a_re    (r_s1_vld),
        .i_a_raddr ({r_bank, r_s1_y}),
        .o_a_rdata (w_acc_rdata),
        .i_b_re    (bus.rd_en),
        .i_b_raddr ({~r_bank, bus.rd_addr}),
        .o_b_rdata (w_rd_rdata)
    );

    assign bus.rd_data    = r_rd_mask ? '0 : w_rd_rdata;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.hist_ready = r_hist_ready;
    assign bus.frame_done = r_frame_done;
    assign bus.drop_err   = r_drop_err;

endmodule

// File: tb/tb_hdmi_hist_accum.sv
// Directed bench: a 22-bit and a 4-bit counter instance share one stimulus stream.
module tb_hdmi_hist_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, vid_de, vid_vs, rd_en, err_clr;
    logic [23:0] vid_rgb;
    logic [7:0]  rd_addr;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    always #5 clk = ~clk;

    hdmi_hist_accum_if #(.CNT_W(22)) bus22 ();
    hdmi_hist_accum_if #(.CNT_W(4))  bus4 ();

    assign bus22.en = en;      assign bus4.en = en;
    assign bus22.vid_rgb = vid_rgb; assign bus4.vid_rgb = vid_rgb;
    assign bus22.vid_de = vid_de;   assign bus4.vid_de = vid_de;
    assign bus22.vid_vs = vid_vs;   assign bus4.vid_vs = vid_vs;
    assign bus22.rd_en = rd_en;     assign bus4.rd_en = rd_en;
    assign bus22.rd_addr = rd_addr; assign bus4.rd_addr = rd_addr;
    assign bus22.err_clr = err_clr; assign bus4.err_clr = err_clr;

    hdmi_hist_accum #(.CNT_W(22), .VS_POL(1'b1)) u_dut22 (
        .clk (clk),
        .rst (rst),
        .bus (bus22.slave)
    );

    hdmi_hist_accum #(.CNT_W(4), .VS_POL(1'b1)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    always @(negedge clk) if (bus22.frame_done) fd_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input int exp);
        int exp4;
        exp4 = (exp > 15) ? 15 : exp;
        rd_en   = 1'b1;
        rd_addr = addr;
        tick(1);
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(bus22.rd_valid), 1);
        check({tag, "_data"}, 32'(bus22.rd_data), exp);
        check({tag, "_data_w4"}, 32'(bus4.rd_data), exp4);
        tick(1);
        check({tag, "_valid_off"}, 32'(bus22.rd_valid), 0);
    endtask

    task automatic send_pix(input logic [23:0] rgb, input int n);
        for (int i = 0; i < n; i++) begin
            vid_de  = 1'b1;
            vid_rgb = rgb;
            tick(1);
        end
        vid_de = 1'b0;
    endtask

    task automatic start_frame();
        vid_vs = 1'b1;
        tick(2);
        vid_vs = 1'b0;
        tick(4);
    endtask

    task automatic end_frame(input string tag);
        bit seen;
        seen   = 1'b0;
        vid_vs = 1'b1;
        tick(2);
        vid_vs = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (bus22.frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_frame_done"}, 32'(seen), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; vid_de = 1'b0; vid_vs = 1'b0; vid_rgb = '0;
        rd_en = 1'b0; rd_addr = '0; err_clr = 1'b0;
        tick(3);
        check("rst_hist_ready", 32'(bus22.hist_ready), 0);
        check("rst_frame_done", 32'(bus22.frame_done), 0);
        check("rst_drop_err", 32'(bus22.drop_err), 0);
        check("rst_rd_valid", 32'(bus22.rd_valid), 0);
        check("rst_rd_data", 32'(bus22.rd_data), 0);
        rst = 1'b0;

        // Idle with vs inactive: nothing completes, reads return zero.
        tick(300);
        check("t1_no_frame_done", 32'(fd_cnt), 0);
        check("t1_hist_ready", 32'(bus22.hist_ready), 0);
        read_check("t1_bin0", 8'd0, 0);

        // First full frame: 100 black pixels.
        start_frame();
        send_pix(24'h000000, 100);
        end_frame("t2");
        tick(1);
        check("t2_pulse_width", 32'(bus22.frame_done), 0);
        check("t2_fd_count", 32'(fd_cnt), 1);
        check("t2_hist_ready", 32'(bus22.hist_ready), 1);
        check("t2_drop_err", 32'(bus22.drop_err), 0);
        read_check("t2_bin0", 8'd0, 100);
        read_check("t2_bin255", 8'd255, 0);

        // Same-bin hazards at distance 1 and 2.
        tick(300);
        send_pix(24'hFFFFFF, 10);
        for (int i = 0; i < 4; i++) begin
            send_pix(24'h808080, 1);
            send_pix(24'hFFFFFF, 1);
        end
        end_frame("t3");
        read_check("t3_bin255", 8'd255, 14);
        read_check("t3_bin128", 8'd128, 4);
        read_check("t3_bin0", 8'd0, 0);

        // Pixel during CLEAR is dropped and flagged.
        send_pix(24'h000000, 1);
        check("t4_drop_set", 32'(bus22.drop_err), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_drop_clr", 32'(bus22.drop_err), 0);

        // 20 pixels: exact in 22 bits, saturated at 15 in 4 bits; dropped pixel absent.
        tick(300);
        send_pix(24'h000000, 20);
        end_frame("t5");
        read_check("t5_bin0", 8'd0, 20);
        read_check("t5_bin255", 8'd255, 0);
        check("t5_drop_err", 32'(bus22.drop_err), 0);

        // Reset in the middle of an accumulating frame.
        tick(300);
        send_pix(24'h808080, 50);
        rst = 1'b1;
        tick(2);
        check("t6_rst_hist_ready", 32'(bus22.hist_ready), 0);
        check("t6_rst_frame_done", 32'(bus22.frame_done), 0);
        check("t6_rst_rd_valid", 32'(bus22.rd_valid), 0);
        rst = 1'b0;
        read_check("t6_masked_bin128", 8'd128, 0);

        // After reset the FSM waits for vs: early pixels are dropped.
        tick(300);
        send_pix(24'h808080, 3);
        check("t6_wait_drop", 32'(bus22.drop_err), 1);
        err_clr = 1'b1;
        send_pix(24'h808080, 1);
        check("t6_set_wins", 32'(bus22.drop_err), 1);
        tick(1);
        err_clr = 1'b0;
        check("t6_clr_after", 32'(bus22.drop_err), 0);

        start_frame();
        send_pix(24'h808080, 30);
        end_frame("t6");
        check("t6_hist_ready", 32'(bus22.hist_ready), 1);
        read_check("t6_bin128", 8'd128, 30);
        read_check("t6_bin0", 8'd0, 0);
        check("t6_fd_total", 32'(fd_cnt), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_hist_accum.md
Name: hdmi_hist_accum

Overview:
- Per-frame luminance histogram stage directly downstream of the HDMI FIR pixel path; consumes the filtered RGB stream (de/vs) and produces the histogram bins that the AXI register block reads.
- Ping-pong storage: one bank accumulates the current frame while the other holds the last completed frame for readout.

Parameters:
- CNT_W, 22, bin counter width (1920x1080 = 2,073,600 fits in 22 bits); counts saturate at 2^CNT_W-1.
- VS_POL, 1, active level of vid_vs; a frame boundary is the edge into the active level.

Ports:
- clk  in  1  pixel clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  histogram enable, sampled at frame start.
- vid_rgb  in  24  {R,G,B}, 8 bits each, from the FIR stage.
- vid_de  in  1  data enable.
- vid_vs  in  1  vertical sync.
- rd_en  in  1  bin read strobe from the AXI side.
- rd_addr  in  8  bin index 0..255.
- rd_data  out  CNT_W  bin count of the completed bank.
- rd_valid  out  1  asserted 1 cycle after rd_en.
- hist_ready  out  1  at least one complete frame is held in the readable bank.
- frame_done  out  1  one-cycle pulse when the banks swap.
- drop_err  out  1  sticky flag: a pixel with de=1 arrived while not counting in ACCUM.
- err_clr  in  1  clears drop_err.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, hist_ready=0, frame_done=0, drop_err=0. Accumulation bank select=0. FSM goes to CLEAR.
- Luma: Y = (77*R + 150*G + 29*B) >> 8, unsigned 8-bit, registered (1 cycle). Y is the bin index.
- vs_edge: registered detection of vid_vs going to the VS_POL level.
- FSM states:
  - CLEAR: writes 0 to acc-bank addresses 0..255, one per cycle (256 cycles). Then goes to ACCUM if the previous frame completed normally, otherwise to WAIT_VS.
  - WAIT_VS: idle. On vs_edge with en=1, goes to ACCUM.
  - ACCUM: each de=1 pixel increments bin[Y]. On vs_edge, goes to DRAIN.
  - DRAIN: waits until the RMW pipeline is empty (<=3 cycles). Then toggles the bank select, pulses frame_done, sets hist_ready=1, and goes to CLEAR.
  - After CLEAR completes following a DRAIN, the FSM goes to ACCUM if en=1, else WAIT_VS.
  - After reset, the first CLEAR always goes to WAIT_VS, so a partial first frame is never counted.
- RMW pipeline (read latency 1):
  - S1: luma register.
  - S2: read acc[Y].
  - S3: write acc[Y] = sat(old+1).
  - Same-bin hazard: if S3 writes the address S2 reads, forward the S3 write value. Back-to-back identical bins must count exactly.
- Saturation: a count at 2^CNT_W-1 stays at that value.
- Dropped pixels: a de=1 pixel seen in CLEAR, DRAIN or WAIT_VS with en=1 and the FSM not in ACCUM is not counted and sets drop_err. err_clr clears drop_err; if a set and a clear occur in the same cycle, set wins.
- Readout:
  - rd_data is the completed-bank bin rd_addr, valid 1 cycle after rd_en (rd_valid pulse).
  - The bank is the one readable in the cycle rd_en is sampled; a swap in that same cycle does not affect the returned data.
  - Reads while hist_ready=0 return 0 with rd_valid asserted.
- Mid-operation reset: any state returns to reset values and CLEAR. Pipeline contents are discarded, and the readable bank is not trusted (hist_ready=0).

Decomposition:
- Package hdmi_hist_pkg holds:
  - NBINS=256 and BIN_W=8.
  - Luma coefficients 77/150/29.
  - The FSM state enum {CLEAR, WAIT_VS, ACCUM, DRAIN}.
- Sub-module hist_bank_ram: 512 x CNT_W true dual-port RAM, address = {bank, bin}.
  - Port A: RMW and clear, in the acc bank.
  - Port B: readout, in the other bank.
  - Both ports have read latency 1.

Test Plan:
1. Reset, then hold vs inactive for 300 cycles -> no frame_done, hist_ready=0. A read of bin 0 returns 0 with rd_valid 1 cycle later.
2. vs edge (en=1), then 100 pixels of 0x000000 with de=1, then vs edge -> one frame_done pulse, hist_ready=1. Reading bin 0 gives 100; bin 255 gives 0.
3. Hazard/forwarding: in one frame send 10 back-to-back 0xFFFFFF pixels, then alternating 0x808080/0xFFFFFF x4 -> bin 255=14, bin 128=4.
4. de=1 pixel during CLEAR (right after frame_done) -> drop_err=1 and the pixel is not counted in the next frame. err_clr pulse gives drop_err=0.
5. CNT_W=4: 20 pixels of 0x000000 in one frame -> bin 0 reads 15 (saturated), with no wrap.
6. rst asserted mid-ACCUM after 50 pixels -> hist_ready=0. The next full frame of 30 pixels at 0x808080 reads bin 128=30.
